// File: rtl/vgachargen_apb_if_if.sv
// APB3 bus bundle between the CPU-side master and the vgachargen memory bridge.
interface vgachargen_apb_if_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [15:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/vgachargen_apb_if.sv
// APB3 slave giving the CPU access to port A of the ch_map, col_map and ch_t_rw BRAMs;
// glyph rows are updated by read-modify-write so they can be written one 32-bit lane at a time.
module vgachargen_apb_if #(
    parameter int CH_MAP_ADDR_WIDTH  = 12,
    parameter int CH_MAP_DATA_WIDTH  = 8,
    parameter int COL_MAP_DATA_WIDTH = 8,
    parameter int CH_T_ADDR_WIDTH    = 7,
    parameter int CH_T_DATA_WIDTH    = 128
) (
    input  logic                          clk_i,
    input  logic                          arstn_i,
    vgachargen_apb_if_if.slave            apb,
    output logic [CH_MAP_ADDR_WIDTH-1:0]  ch_map_addr_o,
    output logic [CH_MAP_DATA_WIDTH-1:0]  ch_map_data_o,
    output logic                          ch_map_wen_o,
    input  logic [CH_MAP_DATA_WIDTH-1:0]  ch_map_data_i,
    output logic [CH_MAP_ADDR_WIDTH-1:0]  col_map_addr_o,
    output logic [COL_MAP_DATA_WIDTH-1:0] col_map_data_o,
    output logic                          col_map_wen_o,
    input  logic [COL_MAP_DATA_WIDTH-1:0] col_map_data_i,
    output logic [CH_T_ADDR_WIDTH-1:0]    ch_t_rw_addr_o,
    output logic [CH_T_DATA_WIDTH-1:0]    ch_t_rw_data_o,
    output logic                          ch_t_rw_wen_o,
    input  logic [CH_T_DATA_WIDTH-1:0]    ch_t_rw_data_i
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        MAP_WR    = 3'd1,
        RD_RESP   = 3'd2,
        RMW_MERGE = 3'd3,
        RMW_WR    = 3'd4,
        ERR       = 3'd5
    } state_t;

    state_t                      state_r;
    state_t                      state_n_s;
    logic [CH_T_DATA_WIDTH-1:0]  merge_r;
    logic [CH_T_DATA_WIDTH-1:0]  merged_s;
    logic [1:0]                  region_s;
    logic [11:0]                 word_s;
    logic [1:0]                  lane_s;
    logic                        err_s;
    logic [31:0]                 lane_rd_s;
    logic [31:0]                 rd_mux_s;
    logic                        unused_s;

    assign region_s = apb.paddr[15:14];
    assign word_s   = apb.paddr[13:2];
    assign lane_s   = word_s[1:0];
    assign unused_s = ^apb.paddr[1:0];

    // Glyph words above the 128-glyph table and the top region are unmapped.
    assign err_s = (region_s == 2'b11) || ((region_s == 2'b10) && (word_s[11:9] != 3'd0));

    // BRAM addresses follow paddr directly so the read data lands one cycle after A1.
    assign ch_map_addr_o  = word_s[CH_MAP_ADDR_WIDTH-1:0];
    assign col_map_addr_o = word_s[CH_MAP_ADDR_WIDTH-1:0];
    assign ch_t_rw_addr_o = word_s[CH_T_ADDR_WIDTH+1:2];
    assign ch_t_rw_data_o = merge_r;

    // Lane extraction and lane replacement on the current glyph row.
    always_comb begin
        lane_rd_s = ch_t_rw_data_i[{lane_s, 5'd0} +: 32];
        merged_s  = ch_t_rw_data_i;
        merged_s[{lane_s, 5'd0} +: 32] = apb.pwdata;
    end

    // Read data selection by region.
    always_comb begin
        rd_mux_s = 32'd0;
        case (region_s)
            2'b00:   rd_mux_s = {{(32-CH_MAP_DATA_WIDTH){1'b0}}, ch_map_data_i};
            2'b01:   rd_mux_s = {{(32-COL_MAP_DATA_WIDTH){1'b0}}, col_map_data_i};
            2'b10:   rd_mux_s = lane_rd_s;
            default: rd_mux_s = 32'd0;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Merge register, loaded only while the access is still selected.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            merge_r <= {CH_T_DATA_WIDTH{1'b0}};
        end else if ((state_r == RMW_MERGE) && apb.psel) begin
            merge_r <= merged_s;
        end else begin
            merge_r <= merge_r;
        end
    end

    // Next-state decode; a dropped psel outside IDLE aborts the transfer.
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            IDLE: begin
                if (apb.psel && apb.penable) begin
                    if (err_s) begin
                        state_n_s = ERR;
                    end else if (!apb.pwrite) begin
                        state_n_s = RD_RESP;
                    end else if (region_s == 2'b10) begin
                        state_n_s = RMW_MERGE;
                    end else begin
                        state_n_s = MAP_WR;
                    end
                end else begin
                    state_n_s = IDLE;
                end
            end
            RMW_MERGE: state_n_s = apb.psel ? RMW_WR : IDLE;
            MAP_WR, RD_RESP, RMW_WR, ERR: state_n_s = IDLE;
            default: state_n_s = IDLE;
        endcase
    end

    // Response and write-enable outputs, all gated by psel so an abort issues nothing.
    always_comb begin
        apb.pready     = 1'b0;
        apb.pslverr    = 1'b0;
        apb.prdata     = 32'd0;
        ch_map_wen_o   = 1'b0;
        col_map_wen_o  = 1'b0;
        ch_t_rw_wen_o  = 1'b0;
        ch_map_data_o  = {CH_MAP_DATA_WIDTH{1'b0}};
        col_map_data_o = {COL_MAP_DATA_WIDTH{1'b0}};
        if (apb.psel) begin
            case (state_r)
                MAP_WR: begin
                    apb.pready     = 1'b1;
                    ch_map_wen_o   = (region_s == 2'b00);
                    col_map_wen_o  = (region_s == 2'b01);
                    ch_map_data_o  = apb.pwdata[CH_MAP_DATA_WIDTH-1:0];
                    col_map_data_o = apb.pwdata[COL_MAP_DATA_WIDTH-1:0];
                end
                RD_RESP: begin
                    apb.pready = 1'b1;
                    apb.prdata = rd_mux_s;
                end
                RMW_WR: begin
                    apb.pready    = 1'b1;
                    ch_t_rw_wen_o = 1'b1;
                end
                ERR: begin
                    apb.pready  = 1'b1;
                    apb.pslverr = 1'b1;
                end
                default: apb.pready = 1'b0;
            endcase
        end else begin
            apb.pready = 1'b0;
        end
    end

endmodule

// File: tb/tb_vgachargen_apb_if.sv
// Directed bench for vgachargen_apb_if with behavioural port-A BRAM models.
module tb_vgachargen_apb_if;

    logic clk = 1'b0;
    logic arstn;
    always #5 clk = ~clk;

    vgachargen_apb_if_if bus ();

    logic [11:0]  ch_map_addr, col_map_addr;
    logic [7:0]   ch_map_wdata, col_map_wdata, ch_map_rd, col_map_rd;
    logic         ch_map_wen, col_map_wen, ch_t_wen;
    logic [6:0]   ch_t_addr;
    logic [127:0] ch_t_wdata, ch_t_rd;

    vgachargen_apb_if dut (
        .clk_i          (clk),
        .arstn_i        (arstn),
        .apb            (bus),
        .ch_map_addr_o  (ch_map_addr),
        .ch_map_data_o  (ch_map_wdata),
        .ch_map_wen_o   (ch_map_wen),
        .ch_map_data_i  (ch_map_rd),
        .col_map_addr_o (col_map_addr),
        .col_map_data_o (col_map_wdata),
        .col_map_wen_o  (col_map_wen),
        .col_map_data_i (col_map_rd),
        .ch_t_rw_addr_o (ch_t_addr),
        .ch_t_rw_data_o (ch_t_wdata),
        .ch_t_rw_wen_o  (ch_t_wen),
        .ch_t_rw_data_i (ch_t_rd)
    );

    logic [7:0]   ch_map_mem [4096];
    logic [7:0]   col_map_mem [4096];
    logic [127:0] ch_t_mem [128];
    logic         pre_we = 1'b0;
    logic [6:0]   pre_addr = 7'd0;
    logic [127:0] pre_data = 128'd0;

    // Synchronous BRAMs, read-before-write, one-cycle read latency.
    always @(posedge clk) begin
        if (ch_map_wen) ch_map_mem[ch_map_addr] <= ch_map_wdata;
        if (col_map_wen) col_map_mem[col_map_addr] <= col_map_wdata;
        if (pre_we) ch_t_mem[pre_addr] <= pre_data;
        else if (ch_t_wen) ch_t_mem[ch_t_addr] <= ch_t_wdata;
        ch_map_rd  <= ch_map_mem[ch_map_addr];
        col_map_rd <= col_map_mem[col_map_addr];
        ch_t_rd    <= ch_t_mem[ch_t_addr];
    end

    int ch_map_wen_cnt = 0, col_map_wen_cnt = 0, ch_t_wen_cnt = 0;
    logic [11:0] last_col_addr = 12'd0;
    logic [11:0] last_ch_map_addr = 12'd0;

    // Write-enable pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (ch_map_wen) begin
            ch_map_wen_cnt   <= ch_map_wen_cnt + 1;
            last_ch_map_addr <= ch_map_addr;
        end
        if (col_map_wen) begin
            col_map_wen_cnt <= col_map_wen_cnt + 1;
            last_col_addr   <= col_map_addr;
        end
        if (ch_t_wen) ch_t_wen_cnt <= ch_t_wen_cnt + 1;
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic apb_xfer(input logic [15:0] addr, input logic wr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output logic err, output int cycles);
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = wr;
        bus.paddr   = addr;
        bus.pwdata  = wdata;
        rdata  = 32'd0;
        err    = 1'b0;
        cycles = 0;
        @(posedge clk); #1;
        bus.penable = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (bus.pready) begin
                cycles = i;
                rdata  = bus.prdata;
                err    = bus.pslverr;
                break;
            end
        end
        @(posedge clk); #1;
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
    endtask

    task automatic preload(input logic [6:0] a, input logic [127:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    task automatic test_reset();
        arstn = 1'b0;
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
        bus.paddr = 16'd0; bus.pwdata = 32'd0;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.pready !== 1'b0) begin n_fail++; $display("FAIL reset_pready got %b want 0", bus.pready); end
        n_checks++; if (bus.pslverr !== 1'b0) begin n_fail++; $display("FAIL reset_pslverr got %b want 0", bus.pslverr); end
        n_checks++; if (bus.prdata !== 32'd0) begin n_fail++; $display("FAIL reset_prdata got %h want 0", bus.prdata); end
        n_checks++; if ({ch_map_wen, col_map_wen, ch_t_wen} !== 3'b000) begin n_fail++; $display("FAIL reset_wen got %b want 000", {ch_map_wen, col_map_wen, ch_t_wen}); end
        n_checks++; if (ch_t_wdata !== 128'd0) begin n_fail++; $display("FAIL reset_merge got %h want 0", ch_t_wdata); end
        arstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_ch_map();
        logic [31:0] rd; logic er; int cyc; int w0;
        w0 = ch_map_wen_cnt;
        apb_xfer(16'h0040, 1'b1, 32'hFFFF_FF8A, rd, er, cyc);
        n_checks++; if (cyc !== 2) begin n_fail++; $display("FAIL chmap_wr_latency got %0d want 2", cyc); end
        n_checks++; if (ch_map_wen_cnt - w0 !== 1) begin n_fail++; $display("FAIL chmap_wen_pulses got %0d want 1", ch_map_wen_cnt - w0); end
        n_checks++; if (last_ch_map_addr !== 12'h010) begin n_fail++; $display("FAIL chmap_addr got %h want 010", last_ch_map_addr); end
        n_checks++; if (ch_map_mem[12'h010] !== 8'h8A) begin n_fail++; $display("FAIL chmap_mem got %h want 8a", ch_map_mem[12'h010]); end
        apb_xfer(16'h0040, 1'b0, 32'd0, rd, er, cyc);
        n_checks++; if (cyc !== 2) begin n_fail++; $display("FAIL chmap_rd_latency got %0d want 2", cyc); end
        n_checks++; if (rd !== 32'h0000_008A) begin n_fail++; $display("FAIL chmap_rd got %h want 0000008a", rd); end
    endtask

    task automatic test_col_map();
        logic [31:0] rd; logic er; int cyc; int w0, c0;
        w0 = col_map_wen_cnt; c0 = ch_map_wen_cnt;
        apb_xfer(16'h4014, 1'b1, 32'h0000_00F0, rd, er, cyc);
        n_checks++; if (col_map_wen_cnt - w0 !== 1) begin n_fail++; $display("FAIL colmap_wen_pulses got %0d want 1", col_map_wen_cnt - w0); end
        n_checks++; if (ch_map_wen_cnt !== c0) begin n_fail++; $display("FAIL colmap_chmap_wen got %0d want %0d", ch_map_wen_cnt, c0); end
        n_checks++; if (last_col_addr !== 12'd5) begin n_fail++; $display("FAIL colmap_addr got %h want 005", last_col_addr); end
        apb_xfer(16'h4014, 1'b0, 32'd0, rd, er, cyc);
        n_checks++; if (rd !== 32'h0000_00F0) begin n_fail++; $display("FAIL colmap_rd got %h want 000000f0", rd); end
    endtask

    task automatic test_ch_t_rmw();
        logic [31:0] rd; logic er; int cyc; int w0;
        logic [31:0] exp_lane [4];
        exp_lane[0] = 32'hFFFF_FFFF; exp_lane[1] = 32'hFFFF_FFFF;
        exp_lane[2] = 32'h1234_5678; exp_lane[3] = 32'hFFFF_FFFF;
        preload(7'd3, {128{1'b1}});
        w0 = ch_t_wen_cnt;
        apb_xfer(16'h8038, 1'b1, 32'h1234_5678, rd, er, cyc);
        n_checks++; if (cyc !== 3) begin n_fail++; $display("FAIL cht_wr_latency got %0d want 3", cyc); end
        n_checks++; if (ch_t_wen_cnt - w0 !== 1) begin n_fail++; $display("FAIL cht_wen_pulses got %0d want 1", ch_t_wen_cnt - w0); end
        n_checks++; if (ch_t_mem[3] !== 128'hFFFFFFFF_12345678_FFFFFFFF_FFFFFFFF) begin n_fail++; $display("FAIL cht_row got %h want ffffffff12345678ffffffffffffffff", ch_t_mem[3]); end
        for (int l = 0; l < 4; l++) begin
            apb_xfer(16'h8030 + 16'(l * 4), 1'b0, 32'd0, rd, er, cyc);
            n_checks++; if (rd !== exp_lane[l] || cyc !== 2) begin n_fail++; $display("FAIL cht_rd_lane%0d got %h/%0d want %h/2", l, rd, cyc, exp_lane[l]); end
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int cyc; int wsum;
        logic [15:0] addrs [3];
        addrs[0] = 16'hC000; addrs[1] = 16'h8800; addrs[2] = 16'hFFFC;
        wsum = ch_map_wen_cnt + col_map_wen_cnt + ch_t_wen_cnt;
        for (int i = 0; i < 3; i++) begin
            for (int w = 0; w < 2; w++) begin
                apb_xfer(addrs[i], w[0], 32'hA5A5_A5A5, rd, er, cyc);
                n_checks++; if (er !== 1'b1 || cyc !== 2 || rd !== 32'd0) begin n_fail++; $display("FAIL err_%h_wr%0d got slverr=%b cyc=%0d rd=%h want 1/2/0", addrs[i], w, er, cyc, rd); end
            end
        end
        n_checks++; if (ch_map_wen_cnt + col_map_wen_cnt + ch_t_wen_cnt !== wsum) begin n_fail++; $display("FAIL err_no_wen got %0d want %0d", ch_map_wen_cnt + col_map_wen_cnt + ch_t_wen_cnt, wsum); end
    endtask

    task automatic test_reset_mid_rmw();
        logic [31:0] rd; logic er; int cyc; int w0;
        preload(7'd4, 128'hA5A5A5A5_5A5A5A5A_A5A5A5A5_5A5A5A5A);
        w0 = ch_t_wen_cnt;
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
        bus.paddr = 16'h8040; bus.pwdata = 32'h0BAD_0BAD;
        @(posedge clk); #1;
        bus.penable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (bus.pready !== 1'b0) begin n_fail++; $display("FAIL rstmid_merge_pready got %b want 0", bus.pready); end
        arstn = 1'b0;
        #1;
        n_checks++; if (ch_t_wdata !== 128'd0 || ch_t_wen !== 1'b0 || bus.pready !== 1'b0) begin n_fail++; $display("FAIL rstmid_outputs got data=%h wen=%b rdy=%b want 0", ch_t_wdata, ch_t_wen, bus.pready); end
        repeat (2) @(negedge clk);
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
        arstn = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (ch_t_wen_cnt !== w0 || ch_t_mem[4] !== 128'hA5A5A5A5_5A5A5A5A_A5A5A5A5_5A5A5A5A) begin n_fail++; $display("FAIL rstmid_no_write got cnt=%0d row=%h want %0d unchanged", ch_t_wen_cnt, ch_t_mem[4], w0); end
        apb_xfer(16'h8040, 1'b1, 32'hCAFE_F00D, rd, er, cyc);
        n_checks++; if (cyc !== 3 || ch_t_mem[4] !== 128'hA5A5A5A5_5A5A5A5A_A5A5A5A5_CAFEF00D) begin n_fail++; $display("FAIL rstmid_post_write got cyc=%0d row=%h want 3/a5a5a5a55a5a5a5aa5a5a5a5cafef00d", cyc, ch_t_mem[4]); end
    endtask

    task automatic test_abort();
        logic [31:0] rd; logic er; int cyc; int w0;
        preload(7'd5, 128'h00112233_44556677_8899AABB_CCDDEEFF);
        w0 = ch_t_wen_cnt;
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
        bus.paddr = 16'h8054; bus.pwdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        bus.penable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (ch_t_wen_cnt !== w0) begin n_fail++; $display("FAIL abort_wen got %0d want %0d", ch_t_wen_cnt, w0); end
        n_checks++; if (ch_t_mem[5] !== 128'h00112233_44556677_8899AABB_CCDDEEFF) begin n_fail++; $display("FAIL abort_row got %h want unchanged", ch_t_mem[5]); end
        @(posedge clk); #1;
        apb_xfer(16'h8054, 1'b0, 32'd0, rd, er, cyc);
        n_checks++; if (rd !== 32'h8899_AABB || cyc !== 2) begin n_fail++; $display("FAIL abort_next_rd got %h/%0d want 8899aabb/2", rd, cyc); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er; int cyc;
        apb_xfer(16'h048C, 1'b1, 32'h0000_005A, rd, er, cyc);
        apb_xfer(16'h448C, 1'b1, 32'h0000_003C, rd, er, cyc);
        apb_xfer(16'h048C, 1'b0, 32'd0, rd, er, cyc);
        n_checks++; if (rd !== 32'h0000_005A || cyc !== 2) begin n_fail++; $display("FAIL b2b_chmap got %h/%0d want 0000005a/2", rd, cyc); end
        apb_xfer(16'h448C, 1'b0, 32'd0, rd, er, cyc);
        n_checks++; if (rd !== 32'h0000_003C || cyc !== 2) begin n_fail++; $display("FAIL b2b_colmap got %h/%0d want 0000003c/2", rd, cyc); end
    endtask

    initial begin
        test_reset();
        test_ch_map();
        test_col_map();
        test_ch_t_rmw();
        test_errors();
        test_reset_mid_rmw();
        test_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
